arpeggio_scheduler: RTL and testbench

Round-robin note scheduler that shares the synthesizer's single tone rate divider among up to eight held keys. Each beat it picks the next held key, loads that key's period into the divider's `count_up_to`, and lets the tone run for one beat. It then silences the divider for a short gap before the next pick. It sits between the key-input logic and the tone rate divider, and drives the divider's count and synchronous active-high reset.

---
 rtl/synth_pkg.sv | 18 +
 rtl/rr_key_picker.sv | 29 ++
 rtl/arpeggio_scheduler.sv | 89 ++++++++
 tb/tb_arpeggio_scheduler.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared synthesizer definitions: per-key tone divider periods and the
// arpeggiator state encoding.
package synth_pkg;

    // Divider periods for C4..C5 at 50 MHz, with the divider stepping by 4 per clock.
    localparam logic [31:0] NOTE_PERIOD [0:7] = '{
        32'd382226, 32'd340530, 32'd303370, 32'd286344,
        32'd255102, 32'd227273, 32'd202478, 32'd191113
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } arp_state_t;

endpackage

// File: rtl/rr_key_picker.sv
// Combinational round-robin picker: first set bit of mask searching upward
// from ptr+1 with wrap-around. ptr itself is checked last.
module rr_key_picker #(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         found
);

    logic [W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = N; i >= 1; i--) begin
            idx = W'((32'(ptr) + i) % N);
            if (mask[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arpeggio_scheduler.sv
// Round-robin arpeggiator: time-shares one tone rate divider among the held
// keys, one beat per note with a silent gap between notes.
module arpeggio_scheduler
    import synth_pkg::*;
#(
    parameter int NUM_KEYS    = 8,
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_250_000,
    localparam int KW         = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [31:0]         count_up_to,
    output logic                divider_reset,
    output logic                gate,
    output logic [KW-1:0]       cur_key,
    output logic                beat_pulse
);

    localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYCLES - 1);
    localparam logic [31:0] GAP_LAST  = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;

    arp_state_t    state, state_n;
    logic [KW-1:0] ptr;
    logic [KW-1:0] winner;
    logic          found;
    logic          load;
    logic [31:0]   cnt;

    rr_key_picker #(.N(NUM_KEYS), .W(KW)) u_picker (
        .mask   (keys),
        .ptr    (ptr),
        .winner (winner),
        .found  (found)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= KW'(NUM_KEYS - 1);
            cur_key     <= '0;
            count_up_to <= '0;
            cnt         <= '0;
        end else begin
            state <= state_n;
            // Counter restarts on every state entry, so it never needs to wrap.
            if (state_n != state || state == IDLE)
                cnt <= '0;
            else
                cnt <= cnt + 32'd1;
            if (load) begin
                ptr         <= winner;
                cur_key     <= winner;
                count_up_to <= NOTE_PERIOD[3'(winner)];
            end
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE: if (keys != '0) state_n = LOAD;
            LOAD: begin
                if (found) begin
                    state_n = PLAY;
                    load    = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            PLAY: if (cnt == BEAT_LAST) state_n = (GAP_CYCLES == 0) ? LOAD : GAP;
            GAP:  if (cnt == GAP_LAST)  state_n = (keys != '0) ? LOAD : IDLE;
            default: state_n = IDLE;
        endcase
        if (!enable) begin
            state_n = IDLE;
            load    = 1'b0;
        end
    end

    // Decoded from registered state only, so async reset silences immediately.
    assign gate          = (state == PLAY);
    assign divider_reset = (state != PLAY);
    assign beat_pulse    = (state == PLAY) && (cnt == BEAT_LAST);

endmodule

// File: tb/tb_arpeggio_scheduler.sv
// Directed bench for arpeggio_scheduler: BEAT=4/GAP=2 instance plus a
// zero-gap instance, with hand-computed note sequences.
module tb_arpeggio_scheduler;

    localparam logic [31:0] NP [0:7] = '{
        32'd382226, 32'd340530, 32'd303370, 32'd286344,
        32'd255102, 32'd227273, 32'd202478, 32'd191113
    };

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        en0 = 1'b0;
    logic [7:0]  keys = '0;
    logic [7:0]  keys0 = '0;
    logic [31:0] cnt_a, cnt_b;
    logic        dr_a, dr_b, g_a, g_b, bp_a, bp_b;
    logic [2:0]  ck_a, ck_b;
    int          checks = 0;
    int          passes = 0;

    always #5 clock = ~clock;

    arpeggio_scheduler #(.NUM_KEYS(8), .BEAT_CYCLES(4), .GAP_CYCLES(2)) u_dut (
        .clock(clock), .reset(reset), .enable(enable), .keys(keys),
        .count_up_to(cnt_a), .divider_reset(dr_a), .gate(g_a),
        .cur_key(ck_a), .beat_pulse(bp_a)
    );

    arpeggio_scheduler #(.NUM_KEYS(8), .BEAT_CYCLES(4), .GAP_CYCLES(0)) u_dut0 (
        .clock(clock), .reset(reset), .enable(en0), .keys(keys0),
        .count_up_to(cnt_b), .divider_reset(dr_b), .gate(g_b),
        .cur_key(ck_b), .beat_pulse(bp_b)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (g_a !== 1'b0) $display("FAIL reset_gate: got %b want 0", g_a); else passes++;
        checks++; if (dr_a !== 1'b1) $display("FAIL reset_divrst: got %b want 1", dr_a); else passes++;
        checks++; if (cnt_a !== 32'd0) $display("FAIL reset_count: got %0d want 0", cnt_a); else passes++;
        checks++; if (ck_a !== 3'd0) $display("FAIL reset_curkey: got %0d want 0", ck_a); else passes++;
        checks++; if (bp_a !== 1'b0) $display("FAIL reset_pulse: got %b want 0", bp_a); else passes++;
        checks++; if (g_b !== 1'b0 || dr_b !== 1'b1) $display("FAIL reset_dut0: gate %b divrst %b want 0/1", g_b, dr_b); else passes++;
        #10;
        reset = 1'b1;
        step();
        checks++; if (g_a !== 1'b0) $display("FAIL idle_gate: got %b want 0", g_a); else passes++;
    endtask

    task automatic test_rotation();
        logic [2:0] seq [0:3];
        seq[0] = 3'd0; seq[1] = 3'd2; seq[2] = 3'd0; seq[3] = 3'd2;
        keys = 8'b0000_0101;
        enable = 1'b1;
        step();
        checks++; if (g_a !== 1'b0) $display("FAIL rot_load_gate: got %b want 0", g_a); else passes++;
        for (int n = 0; n < 4; n++) begin
            for (int c = 0; c < 7; c++) begin
                step();
                checks++; if (g_a !== (c < 4)) $display("FAIL rot_gate n%0d c%0d: got %b want %b", n, c, g_a, (c < 4)); else passes++;
                checks++; if (dr_a !== !(c < 4)) $display("FAIL rot_divrst n%0d c%0d: got %b want %b", n, c, dr_a, !(c < 4)); else passes++;
                checks++; if (bp_a !== (c == 3)) $display("FAIL rot_pulse n%0d c%0d: got %b want %b", n, c, bp_a, (c == 3)); else passes++;
                if (c == 0) begin
                    checks++; if (ck_a !== seq[n]) $display("FAIL rot_curkey n%0d: got %0d want %0d", n, ck_a, seq[n]); else passes++;
                    checks++; if (cnt_a !== NP[seq[n]]) $display("FAIL rot_count n%0d: got %0d want %0d", n, cnt_a, NP[seq[n]]); else passes++;
                end
                if (c == 3) begin
                    checks++; if (cnt_a !== NP[seq[n]]) $display("FAIL rot_count_stable n%0d: got %0d want %0d", n, cnt_a, NP[seq[n]]); else passes++;
                end
            end
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_single_key();
        keys = 8'b1000_0000;
        enable = 1'b1;
        step();
        for (int n = 0; n < 3; n++) begin
            for (int c = 0; c < 7; c++) begin
                step();
                checks++; if (bp_a !== (c == 3)) $display("FAIL single_pulse n%0d c%0d: got %b want %b", n, c, bp_a, (c == 3)); else passes++;
                checks++; if (g_a !== (c < 4)) $display("FAIL single_gate n%0d c%0d: got %b want %b", n, c, g_a, (c < 4)); else passes++;
                if (c == 0) begin
                    checks++; if (ck_a !== 3'd7) $display("FAIL single_curkey n%0d: got %0d want 7", n, ck_a); else passes++;
                    checks++; if (cnt_a !== NP[7]) $display("FAIL single_count n%0d: got %0d want %0d", n, cnt_a, NP[7]); else passes++;
                end
            end
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_zero_gap();
        keys0 = 8'b0000_0011;
        en0 = 1'b1;
        step();
        for (int n = 0; n < 3; n++) begin
            for (int c = 0; c < 5; c++) begin
                step();
                checks++; if (g_b !== (c < 4)) $display("FAIL zgap_gate n%0d c%0d: got %b want %b", n, c, g_b, (c < 4)); else passes++;
                checks++; if (bp_b !== (c == 3)) $display("FAIL zgap_pulse n%0d c%0d: got %b want %b", n, c, bp_b, (c == 3)); else passes++;
                if (c == 0) begin
                    checks++; if (ck_b !== 3'(n % 2)) $display("FAIL zgap_curkey n%0d: got %0d want %0d", n, ck_b, n % 2); else passes++;
                end
            end
        end
        en0 = 1'b0;
        step();
    endtask

    task automatic test_release_mid_note();
        logic [6:0] exp_gate;
        logic [6:0] exp_pulse;
        exp_gate  = 7'b0000011;
        exp_pulse = 7'b0000010;
        keys = 8'b0000_0001;
        enable = 1'b1;
        step();
        step();
        checks++; if (g_a !== 1'b1 || ck_a !== 3'd0) $display("FAIL rel_start: gate %b key %0d want 1/0", g_a, ck_a); else passes++;
        step();
        keys = 8'b0;
        for (int c = 0; c < 7; c++) begin
            step();
            checks++; if (g_a !== exp_gate[c]) $display("FAIL rel_gate c%0d: got %b want %b", c, g_a, exp_gate[c]); else passes++;
            checks++; if (dr_a !== !exp_gate[c]) $display("FAIL rel_divrst c%0d: got %b want %b", c, dr_a, !exp_gate[c]); else passes++;
            checks++; if (bp_a !== exp_pulse[c]) $display("FAIL rel_pulse c%0d: got %b want %b", c, bp_a, exp_pulse[c]); else passes++;
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_enable_drop();
        keys = 8'b0000_0010;
        enable = 1'b1;
        step();
        step();
        checks++; if (g_a !== 1'b1 || ck_a !== 3'd1) $display("FAIL en_start: gate %b key %0d want 1/1", g_a, ck_a); else passes++;
        step();
        enable = 1'b0;
        step();
        checks++; if (g_a !== 1'b0) $display("FAIL en_drop_gate: got %b want 0", g_a); else passes++;
        checks++; if (dr_a !== 1'b1) $display("FAIL en_drop_divrst: got %b want 1", dr_a); else passes++;
        keys = 8'b0000_0110;
        enable = 1'b1;
        step();
        checks++; if (g_a !== 1'b0) $display("FAIL en_load_gate: got %b want 0", g_a); else passes++;
        step();
        checks++; if (g_a !== 1'b1) $display("FAIL en_resume_gate: got %b want 1", g_a); else passes++;
        checks++; if (ck_a !== 3'd2) $display("FAIL en_resume_curkey: got %0d want 2", ck_a); else passes++;
        checks++; if (cnt_a !== NP[2]) $display("FAIL en_resume_count: got %0d want %0d", cnt_a, NP[2]); else passes++;
    endtask

    task automatic test_async_reset();
        #3;
        reset = 1'b0;
        #1;
        checks++; if (g_a !== 1'b0) $display("FAIL arst_gate: got %b want 0", g_a); else passes++;
        checks++; if (dr_a !== 1'b1) $display("FAIL arst_divrst: got %b want 1", dr_a); else passes++;
        checks++; if (cnt_a !== 32'd0) $display("FAIL arst_count: got %0d want 0", cnt_a); else passes++;
        checks++; if (ck_a !== 3'd0) $display("FAIL arst_curkey: got %0d want 0", ck_a); else passes++;
        checks++; if (bp_a !== 1'b0) $display("FAIL arst_pulse: got %b want 0", bp_a); else passes++;
        #2;
        reset = 1'b1;
        step();
        checks++; if (g_a !== 1'b0) $display("FAIL arst_load_gate: got %b want 0", g_a); else passes++;
        step();
        checks++; if (g_a !== 1'b1) $display("FAIL arst_play_gate: got %b want 1", g_a); else passes++;
        checks++; if (ck_a !== 3'd1) $display("FAIL arst_first_pick: got %0d want 1", ck_a); else passes++;
        checks++; if (cnt_a !== NP[1]) $display("FAIL arst_count_pick: got %0d want %0d", cnt_a, NP[1]); else passes++;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_single_key();
        test_zero_gap();
        test_release_mid_note();
        test_enable_drop();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
